// File: rtl/texture_block_fetch.sv
// texture_block_fetch
//   Fetches one 16-byte compressed texture block. The block address is derived from the
//   texture base and the block's (x, y) position. One 8-halfword burst is read, and the
//   halfwords are assembled into a 128-bit little-endian word for the consumer.
//
// Ports
//   clk, rst_n            clock; synchronous active-low reset
//   req_valid/req_ready   request handshake (ready only while idle)
//   req_base_addr         texture base halfword address
//   req_block_x/_y        block column / row
//   req_width_log2        log2 of texture width in blocks (0..8)
//   mem_req/mem_addr      burst read request and start halfword address (held until mem_ack)
//   mem_ack               memory accepted the burst
//   mem_rvalid/mem_rdata  one returned halfword per asserted cycle
//   blk_valid/blk_ready   output handshake
//   blk_data              assembled block, byte 0 at [7:0]
//   busy                  high whenever not idle
module texture_block_fetch #(
  parameter int unsigned ADDR_W = 24
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_base_addr,
  input  logic [7:0]        req_block_x,
  input  logic [7:0]        req_block_y,
  input  logic [3:0]        req_width_log2,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic              mem_rvalid,
  input  logic [15:0]       mem_rdata,
  output logic              blk_valid,
  input  logic              blk_ready,
  output logic [127:0]      blk_data,
  output logic              busy
);

  typedef enum logic [1:0] {StIdle, StReq, StRecv, StOut} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [2:0]        beat_cnt_q, beat_cnt_d;
  logic [127:0]      blk_data_q, blk_data_d;
  logic              req_ready_q, mem_req_q, blk_valid_q, busy_q;

  logic [ADDR_W-1:0] blk_index;
  logic [ADDR_W-1:0] req_addr;

  // Each block is 8 halfwords; everything is computed at ADDR_W bits so overflow wraps.
  always_comb begin
    blk_index = (ADDR_W'(req_block_y) << req_width_log2) + ADDR_W'(req_block_x);
    req_addr  = req_base_addr + (blk_index << 3);
  end

  always_comb begin
    state_d    = state_q;
    mem_addr_d = mem_addr_q;
    beat_cnt_d = beat_cnt_q;
    blk_data_d = blk_data_q;
    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          mem_addr_d = req_addr;
          state_d    = StReq;
        end
      end
      StReq: begin
        // A beat arriving alongside mem_ack is deliberately not captured.
        if (mem_ack) begin
          beat_cnt_d = 3'd0;
          state_d    = StRecv;
        end
      end
      StRecv: begin
        if (mem_rvalid) begin
          blk_data_d[{beat_cnt_q, 4'd0} +: 16] = mem_rdata;
          beat_cnt_d = beat_cnt_q + 3'd1;
          if (beat_cnt_q == 3'd7) begin
            state_d = StOut;
          end
        end
      end
      StOut: begin
        if (blk_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Handshake outputs are registered from the next state so they have no combinational path
  // from any input.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      mem_addr_q  <= '0;
      beat_cnt_q  <= 3'd0;
      blk_data_q  <= '0;
      req_ready_q <= 1'b1;
      mem_req_q   <= 1'b0;
      blk_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      mem_addr_q  <= mem_addr_d;
      beat_cnt_q  <= beat_cnt_d;
      blk_data_q  <= blk_data_d;
      req_ready_q <= (state_d == StIdle);
      mem_req_q   <= (state_d == StReq);
      blk_valid_q <= (state_d == StOut);
      busy_q      <= (state_d != StIdle);
    end
  end

  assign req_ready = req_ready_q;
  assign mem_req   = mem_req_q;
  assign mem_addr  = mem_addr_q;
  assign blk_valid = blk_valid_q;
  assign blk_data  = blk_data_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_texture_block_fetch.sv
// Directed bench for texture_block_fetch. Inputs are driven and outputs sampled on the
// falling clock edge. Expected burst addresses and blocks go into scoreboard queues when the
// stimulus is issued and are popped when the DUT presents mem_req / blk_valid.
module tb_texture_block_fetch;

  localparam int unsigned AW = 24;
  localparam logic [127:0] Seq8 = 128'h0008_0007_0006_0005_0004_0003_0002_0001;

  logic          clk;
  logic          rst_n;
  logic          req_valid;
  logic          req_ready;
  logic [AW-1:0] req_base_addr;
  logic [7:0]    req_block_x;
  logic [7:0]    req_block_y;
  logic [3:0]    req_width_log2;
  logic          mem_req;
  logic [AW-1:0] mem_addr;
  logic          mem_ack;
  logic          mem_rvalid;
  logic [15:0]   mem_rdata;
  logic          blk_valid;
  logic          blk_ready;
  logic [127:0]  blk_data;
  logic          busy;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  logic [AW-1:0] addr_q[$];
  logic [127:0]  blk_q[$];

  texture_block_fetch #(.ADDR_W(AW)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_base_addr  (req_base_addr),
    .req_block_x    (req_block_x),
    .req_block_y    (req_block_y),
    .req_width_log2 (req_width_log2),
    .mem_req        (mem_req),
    .mem_addr       (mem_addr),
    .mem_ack        (mem_ack),
    .mem_rvalid     (mem_rvalid),
    .mem_rdata      (mem_rdata),
    .blk_valid      (blk_valid),
    .blk_ready      (blk_ready),
    .blk_data       (blk_data),
    .busy           (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_req_ready"}, req_ready, 1'b1);
    chk({tag, "_mem_req"}, mem_req, 1'b0);
    chk({tag, "_mem_addr"}, mem_addr, '0);
    chk({tag, "_blk_valid"}, blk_valid, 1'b0);
    chk({tag, "_blk_data"}, blk_data, '0);
    chk({tag, "_busy"}, busy, 1'b0);
  endtask

  // One complete fetch: request, optional ack delay, 8 beats with optional random gaps,
  // optional back-pressure in OUT, then the output handshake.
  task automatic run_fetch(input string tag, input logic [AW-1:0] base, input logic [7:0] x,
                           input logic [7:0] y, input logic [3:0] w, input logic [AW-1:0] exp_addr,
                           input logic [127:0] data, input int ack_delay, input int gap_max,
                           input int hold_cycles, input bit ack_junk, input bit check_lat);
    int t0;
    int waited;
    int gaps;
    logic [AW-1:0] a_exp;
    logic [127:0]  b_exp;

    @(negedge clk);
    chk({tag, "_req_ready_idle"}, req_ready, 1'b1);
    chk({tag, "_mem_req_idle"}, mem_req, 1'b0);
    req_valid      = 1'b1;
    req_base_addr  = base;
    req_block_x    = x;
    req_block_y    = y;
    req_width_log2 = w;
    t0             = cyc;
    addr_q.push_back(exp_addr);

    @(negedge clk);
    req_valid      = 1'b0;
    req_base_addr  = AW'($urandom);
    req_block_x    = 8'($urandom);
    req_block_y    = 8'($urandom);
    chk({tag, "_mem_req_rise"}, mem_req, 1'b1);
    chk({tag, "_busy"}, busy, 1'b1);
    chk({tag, "_req_ready_busy"}, req_ready, 1'b0);
    a_exp = addr_q.pop_front();
    chk({tag, "_mem_addr"}, mem_addr, a_exp);

    for (int i = 0; i < ack_delay; i++) begin
      @(negedge clk);
      chk({tag, "_mem_req_wait"}, mem_req, 1'b1);
      chk({tag, "_mem_addr_stable"}, mem_addr, a_exp);
    end
    mem_ack = 1'b1;
    if (ack_junk) begin
      mem_rvalid = 1'b1;
      mem_rdata  = 16'hDEAD;
    end
    @(negedge clk);
    mem_ack    = 1'b0;
    mem_rvalid = 1'b0;
    chk({tag, "_mem_req_fall"}, mem_req, 1'b0);

    blk_q.push_back(data);
    for (int i = 0; i < 8; i++) begin
      gaps = (gap_max > 0) ? int'($urandom_range(gap_max, 0)) : 0;
      repeat (gaps) @(negedge clk);
      chk({tag, "_no_early_valid"}, blk_valid, 1'b0);
      mem_rvalid = 1'b1;
      mem_rdata  = data[16*i +: 16];
      @(negedge clk);
      mem_rvalid = 1'b0;
      mem_rdata  = 16'($urandom);
    end

    waited = 0;
    while (blk_valid !== 1'b1 && waited < 40) begin
      @(negedge clk);
      waited++;
    end
    chk({tag, "_blk_valid_seen"}, blk_valid, 1'b1);
    // Acceptance cycle counts as cycle 1, so blk_valid first shows in cycle 11.
    if (check_lat) chk({tag, "_latency"}, 32'(cyc - t0), 32'd10);
    b_exp = blk_q.pop_front();
    chk({tag, "_blk_data"}, blk_data, b_exp);

    for (int i = 0; i < hold_cycles; i++) begin
      req_valid = 1'b1;
      @(negedge clk);
      chk({tag, "_hold_valid"}, blk_valid, 1'b1);
      chk({tag, "_hold_data"}, blk_data, b_exp);
      chk({tag, "_hold_req_ready"}, req_ready, 1'b0);
      chk({tag, "_hold_mem_req"}, mem_req, 1'b0);
    end
    req_valid = 1'b0;
    blk_ready = 1'b1;
    @(negedge clk);
    blk_ready = 1'b0;
    chk({tag, "_valid_drop"}, blk_valid, 1'b0);
    chk({tag, "_back_idle"}, req_ready, 1'b1);
    chk({tag, "_busy_idle"}, busy, 1'b0);
    chk({tag, "_mem_req_after"}, mem_req, 1'b0);
    chk({tag, "_data_retained"}, blk_data, b_exp);
  endtask

  initial begin
    rst_n          = 1'b0;
    req_valid      = 1'b0;
    req_base_addr  = '0;
    req_block_x    = '0;
    req_block_y    = '0;
    req_width_log2 = '0;
    mem_ack        = 1'b0;
    mem_rvalid     = 1'b0;
    mem_rdata      = '0;
    blk_ready      = 1'b0;

    repeat (2) @(negedge clk);
    chk_reset_outputs("por");
    rst_n = 1'b1;

    // Gap-free fetch with immediate ack: address and 11-cycle latency.
    run_fetch("basic", 24'h001000, 8'd3, 8'd2, 4'd4, 24'h001118, Seq8, 0, 0, 0, 1'b0, 1'b1);

    // Slow ack, a beat coincident with ack, random gaps: same block must result.
    run_fetch("gaps", 24'h001000, 8'd3, 8'd2, 4'd4, 24'h001118, Seq8, 5, 3, 0, 1'b1, 1'b0);

    // Back-pressure in OUT with a competing request; widest texture.
    run_fetch("hold", 24'h002000, 8'd5, 8'd1, 4'd8, 24'h002828,
              128'hFEDC_BA98_7654_3210_0F1E_2D3C_4B5A_6978, 0, 1, 10, 1'b0, 1'b0);

    // width_log2 = 0 (one block per row).
    run_fetch("w0", 24'h000100, 8'd7, 8'd3, 4'd0, 24'h000150,
              128'h1111_2222_3333_4444_5555_6666_7777_8888, 2, 0, 0, 1'b0, 1'b0);

    // Reset after the 4th beat; the trailing beats must be ignored.
    @(negedge clk);
    req_valid      = 1'b1;
    req_base_addr  = 24'h000400;
    req_block_x    = 8'd2;
    req_block_y    = 8'd1;
    req_width_log2 = 4'd3;
    @(negedge clk);
    req_valid = 1'b0;
    chk("rst_mem_addr", mem_addr, 24'h000450);
    mem_ack = 1'b1;
    @(negedge clk);
    mem_ack = 1'b0;
    for (int i = 0; i < 4; i++) begin
      mem_rvalid = 1'b1;
      mem_rdata  = 16'hA000 + 16'(i);
      @(negedge clk);
    end
    mem_rvalid = 1'b0;
    rst_n      = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk_reset_outputs("midrst");
    for (int i = 4; i < 8; i++) begin
      mem_rvalid = 1'b1;
      mem_rdata  = 16'hA000 + 16'(i);
      @(negedge clk);
      chk("midrst_no_valid", blk_valid, 1'b0);
      chk("midrst_data_clear", blk_data, '0);
      chk("midrst_idle", busy, 1'b0);
    end
    mem_rvalid = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("midrst_no_valid_late", blk_valid, 1'b0);
    end

    // Address wraps by truncation; also confirms recovery after the aborted burst.
    run_fetch("wrap", 24'hFFFFF8, 8'd1, 8'd0, 4'd2, 24'h000000,
              128'hCAFE_BABE_DEAD_BEEF_0123_4567_89AB_CDEF, 1, 2, 0, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/texture_block_fetch.md
TEXTURE_BLOCK_FETCH -- requirements
Module: texture_block_fetch

Interface
REQ-001 The module SHALL have parameter ADDR_W, default 24, giving the halfword (16-bit) address width of the texture memory read port.
REQ-002 The module SHALL have port clk, input, 1 bit: the single clock for all state.
REQ-003 The module SHALL have port rst_n, input, 1 bit: synchronous, active-low reset, sampled on the rising edge of clk.
REQ-004 The module SHALL have port req_valid, input, 1 bit: a block fetch request is present.
REQ-005 The module SHALL have port req_ready, output, 1 bit: the block accepts a request this cycle.
REQ-006 The module SHALL have port req_base_addr, input, ADDR_W bits: texture base halfword address.
REQ-007 The module SHALL have ports req_block_x and req_block_y, input, 8 bits each: block column and row.
REQ-008 The module SHALL have port req_width_log2, input, 4 bits: log2 of texture width in blocks, range 0..8.
REQ-009 The module SHALL have port mem_req, output, 1 bit: burst read request to memory.
REQ-010 The module SHALL have port mem_addr, output, ADDR_W bits: burst start halfword address.
REQ-011 The module SHALL have port mem_ack, input, 1 bit: memory accepted the burst request.
REQ-012 The module SHALL have ports mem_rvalid, input, 1 bit, and mem_rdata, input, 16 bits: one returned halfword per asserted cycle.
REQ-013 The module SHALL have port blk_valid, output, 1 bit, and blk_ready, input, 1 bit: output handshake.
REQ-014 The module SHALL have port blk_data, output, 128 bits: the assembled 16-byte compressed block, little-endian, byte 0 at [7:0].
REQ-015 The module SHALL have port busy, output, 1 bit: high in any state other than IDLE.

Function
REQ-016 The block SHALL implement a four-state FSM: IDLE, REQ, RECV, OUT.
REQ-017 req_ready SHALL be 1 in IDLE only; a request is accepted when req_valid and req_ready are both 1 on a rising edge, and the FSM moves to REQ.
REQ-018 On acceptance, mem_addr SHALL be latched as req_base_addr + ((({req_block_y} << req_width_log2) + req_block_x) << 3), computed in ADDR_W bits, with overflow discarded by truncation.
REQ-019 In REQ, mem_req SHALL be 1, and mem_addr SHALL be held stable until mem_ack is sampled 1; the FSM then moves to RECV, and mem_req is 0 from the following cycle.
REQ-020 mem_req SHALL first assert in the cycle after acceptance (1-cycle latency).
REQ-021 In RECV, a 3-bit beat counter SHALL start at 0 and increment on each mem_rvalid.
REQ-022 In RECV, beat n SHALL write mem_rdata into blk_data[16n+15:16n].
REQ-023 On the 8th beat (counter 7 with mem_rvalid), the FSM SHALL move to OUT; gaps between beats of any length SHALL be tolerated.
REQ-024 mem_rvalid outside RECV, including a beat coincident with the mem_ack cycle in REQ, SHALL be ignored and SHALL NOT alter blk_data.
REQ-025 In OUT, blk_valid SHALL be 1 and blk_data SHALL be held stable; when blk_ready is sampled 1, the FSM SHALL move to IDLE, and blk_valid is 0 from the next cycle.
REQ-026 blk_valid SHALL NOT depend combinationally on blk_ready, and req_ready SHALL NOT depend combinationally on req_valid.
REQ-027 The minimum request-to-blk_valid latency SHALL be 11 cycles: 1 cycle to REQ, 1 cycle for ack, 8 beats, then OUT.
REQ-028 A new request SHALL be accepted no earlier than the cycle after the blk_valid/blk_ready handshake.
REQ-029 blk_data SHALL retain its last value in IDLE.

Reset
REQ-030 While rst_n is 0 at a clock edge, the FSM SHALL enter IDLE with outputs req_ready=1 (from the next cycle), mem_req=0, mem_addr=0, blk_valid=0, blk_data=0, busy=0, and beat counter 0.
REQ-031 A reset asserted mid-burst SHALL abandon the burst, and the remaining mem_rvalid beats after reset release SHALL be ignored per REQ-024.

Verification
REQ-032 The bench SHALL cover: base=0x001000, x=3, y=2, width_log2=4 -> mem_addr=0x001118, mem_req rising 1 cycle after acceptance.
REQ-033 The bench SHALL cover: beats 0x0001..0x0008 with no gaps, blk_ready=1 -> blk_data=0x0008_0007_0006_0005_0004_0003_0002_0001, blk_valid exactly 1 cycle, 11 cycles after acceptance.
REQ-034 The bench SHALL cover: mem_ack delayed 5 cycles, and random 0-3 cycle gaps between beats -> mem_addr stable throughout REQ, blk_data identical to the gap-free case.
REQ-035 The bench SHALL cover: blk_ready held 0 for 10 cycles in OUT -> blk_valid and blk_data stable, req_ready=0, and a new req_valid is not accepted.
REQ-036 The bench SHALL cover: rst_n=0 after the 4th beat, then the remaining 4 beats delivered -> all outputs at reset values, blk_valid never asserts, and the next request fetches correctly.
REQ-037 The bench SHALL cover: base=0xFFFFF8, x=1, y=0 -> mem_addr=0x000000 (wrap by truncation).
